wb_stage_nb: RTL

- Next-generation writeback stage with non-blocking loads. Sits between the memory-access stage and the register file / HI-LO registers.
- Accepts retiring instructions through a valid/ready handshake. Load instructions are queued as descriptors until the data memory returns their data in order, which can take any number of cycles.
- Load data is aligned and extended for byte, halfword and word accesses, then written back.
- Exports a per-register pending-load mask so the decode stage can interlock on pending loads.

---
 rtl/wb_stage_nb_pkg.sv | 27 ++
 rtl/wb_load_align.sv | 50 +++++
 rtl/wb_stage_nb.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/wb_stage_nb_pkg.sv
// Shared definitions for the non-blocking writeback stage.
//   WB_DEPTH   : default number of outstanding loads
//   DRE_*      : load byte-lane enable patterns understood by the aligner
//   ld_desc_t  : per-load descriptor held in the in-order load queue
package wb_stage_nb_pkg;

    localparam int          WB_DEPTH  = 4;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [3:0] DRE_B0  = 4'b0001;
    localparam logic [3:0] DRE_B1  = 4'b0010;
    localparam logic [3:0] DRE_B2  = 4'b0100;
    localparam logic [3:0] DRE_B3  = 4'b1000;
    localparam logic [3:0] DRE_HLO = 4'b0011;
    localparam logic [3:0] DRE_HHI = 4'b1100;
    localparam logic [3:0] DRE_W   = 4'b1111;

    // discard marks loads whose result must be dropped (wa=0 or no GPR write);
    // they still occupy a slot so responses stay matched to requests.
    typedef struct packed {
        logic [4:0] wa;
        logic [3:0] dre;
        logic       sext;
        logic       discard;
    } ld_desc_t;

endpackage

// File: rtl/wb_load_align.sv
// Load data aligner (purely combinational).
//   dm      : raw memory word
//   dre     : byte-lane enables of the load
//   sext    : 1 = sign-extend byte/halfword, 0 = zero-extend
//   data    : aligned, extended writeback value (0 for illegal dre)
//   bad_dre : dre is not a supported byte/halfword/word pattern
module wb_load_align
    import wb_stage_nb_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] dm,
    input  logic [3:0]  dre,
    input  logic        sext,
    output logic [31:0] data,
    output logic        bad_dre
);

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sx);
        logic signed [7:0] bs;
        bs = b;
        return sx ? 32'(bs) : {24'd0, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sx);
        logic signed [15:0] hs;
        hs = h;
        return sx ? 32'(hs) : {16'd0, h};
    endfunction

    function automatic logic [15:0] order16(input logic [15:0] h);
        return BIG_ENDIAN ? {h[7:0], h[15:8]} : h;
    endfunction

    always_comb begin
        data    = ZERO_WORD;
        bad_dre = 1'b0;
        case (dre)
            DRE_B0:  data = ext8(dm[7:0],   sext);
            DRE_B1:  data = ext8(dm[15:8],  sext);
            DRE_B2:  data = ext8(dm[23:16], sext);
            DRE_B3:  data = ext8(dm[31:24], sext);
            DRE_HLO: data = ext16(order16(dm[15:0]),  sext);
            DRE_HHI: data = ext16(order16(dm[31:16]), sext);
            DRE_W:   data = BIG_ENDIAN ? {dm[7:0], dm[15:8], dm[23:16], dm[31:24]} : dm;
            default: bad_dre = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage_nb.sv
// Writeback stage with non-blocking loads.
//   cpu_clk_50M / cpu_rst_n : clock, async active-low reset
//   wb_*_i                  : retiring instruction from the memory stage (valid/ready)
//   dm_valid_i / dm_i       : in-order load data returns from data memory
//   wb_wa_o/wreg_o/wd_o     : registered GPR write port (wreg is a 1-cycle pulse)
//   wb_whilo_o/dhi_o/dlo_o  : registered HI/LO write port (whilo is a 1-cycle pulse)
//   ld_busy_o               : GPRs targeted by queued loads (decode interlock)
//   pend_cnt_o              : number of queued loads
//   err_o                   : sticky error (stray return or illegal dre)
module wb_stage_nb
    import wb_stage_nb_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                         cpu_clk_50M,
    input  logic                         cpu_rst_n,
    input  logic                         wb_valid_i,
    output logic                         wb_ready_o,
    input  logic [4:0]                   wb_wa_i,
    input  logic                         wb_wreg_i,
    input  logic                         wb_mreg_i,
    input  logic                         wb_sext_i,
    input  logic [3:0]                   wb_dre_i,
    input  logic [31:0]                  wb_dreg_i,
    input  logic                         wb_whilo_i,
    input  logic [63:0]                  wb_dhilo_i,
    input  logic                         dm_valid_i,
    input  logic [31:0]                  dm_i,
    output logic [4:0]                   wb_wa_o,
    output logic                         wb_wreg_o,
    output logic [31:0]                  wb_wd_o,
    output logic                         wb_whilo_o,
    output logic [31:0]                  wb_dhi_o,
    output logic [31:0]                  wb_dlo_o,
    output logic [31:0]                  ld_busy_o,
    output logic [$clog2(DEPTH+1)-1:0]   pend_cnt_o,
    output logic                         err_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    ld_desc_t              fifo_q [DEPTH];
    logic [DEPTH-1:0]      ent_vld;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic [31:0]           busy;

    ld_desc_t              head_p0, push_desc_p0;
    logic                  full_p0, pop_p0, alu_wr_p0, acc_p0, push_p0;
    logic [31:0]           ld_data_p0;
    logic                  bad_dre_p0;

    logic                  vld_p1, hilo_vld_p1, err_q;
    logic [4:0]            wa_p1;
    logic [31:0]           wd_p1, dhi_p1, dlo_p1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ---- stage p0: handshake, queue head, alignment ----
    assign head_p0   = fifo_q[rd_ptr];
    assign full_p0   = (cnt == CNT_W'(DEPTH));
    assign pop_p0    = dm_valid_i & (cnt != '0);
    assign alu_wr_p0 = ~wb_mreg_i & wb_wreg_i & (wb_wa_i != 5'd0);

    // The load return owns the single GPR port, and an ALU write may not
    // overtake a queued load to the same register.
    assign wb_ready_o = ~((wb_mreg_i & full_p0 & ~pop_p0) |
                          (alu_wr_p0 & pop_p0) |
                          (alu_wr_p0 & busy[wb_wa_i]));

    assign acc_p0  = wb_valid_i & wb_ready_o;
    assign push_p0 = acc_p0 & wb_mreg_i;

    assign push_desc_p0.wa      = wb_wa_i;
    assign push_desc_p0.dre     = wb_dre_i;
    assign push_desc_p0.sext    = wb_sext_i;
    assign push_desc_p0.discard = ~wb_wreg_i | (wb_wa_i == 5'd0);

    // Recomputed from live entries so duplicate destinations clear only
    // when the last one leaves.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && !fifo_q[i].discard) busy[fifo_q[i].wa] = 1'b1;
        end
        busy[0] = 1'b0;
    end

    wb_load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .dm      (dm_i),
        .dre     (head_p0.dre),
        .sext    (head_p0.sext),
        .data    (ld_data_p0),
        .bad_dre (bad_dre_p0)
    );

    always_ff @(posedge cpu_clk_50M) begin
        if (push_p0) fifo_q[wr_ptr] <= push_desc_p0;
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            ent_vld <= '0;
            err_q   <= 1'b0;
        end else begin
            if (pop_p0) begin
                rd_ptr          <= ptr_inc(rd_ptr);
                ent_vld[rd_ptr] <= 1'b0;
            end
            // Placed after the pop so a push into the slot freed this cycle wins.
            if (push_p0) begin
                wr_ptr          <= ptr_inc(wr_ptr);
                ent_vld[wr_ptr] <= 1'b1;
            end
            case ({push_p0, pop_p0})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if ((dm_valid_i && cnt == '0) || (pop_p0 && bad_dre_p0)) err_q <= 1'b1;
        end
    end

    // ---- stage p1: registered writeback ports ----
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            vld_p1      <= 1'b0;
            wa_p1       <= 5'd0;
            wd_p1       <= ZERO_WORD;
            hilo_vld_p1 <= 1'b0;
            dhi_p1      <= ZERO_WORD;
            dlo_p1      <= ZERO_WORD;
        end else begin
            vld_p1      <= 1'b0;
            hilo_vld_p1 <= 1'b0;
            if (pop_p0) begin
                vld_p1 <= ~head_p0.discard;
                wa_p1  <= head_p0.wa;
                wd_p1  <= ld_data_p0;
            end else if (acc_p0 && alu_wr_p0) begin
                vld_p1 <= 1'b1;
                wa_p1  <= wb_wa_i;
                wd_p1  <= wb_dreg_i;
            end
            if (acc_p0 && wb_whilo_i) begin
                hilo_vld_p1 <= 1'b1;
                dhi_p1      <= wb_dhilo_i[63:32];
                dlo_p1      <= wb_dhilo_i[31:0];
            end
        end
    end

    assign wb_wreg_o  = vld_p1;
    assign wb_wa_o    = wa_p1;
    assign wb_wd_o    = wd_p1;
    assign wb_whilo_o = hilo_vld_p1;
    assign wb_dhi_o   = dhi_p1;
    assign wb_dlo_o   = dlo_p1;
    assign ld_busy_o  = busy;
    assign pend_cnt_o = cnt;
    assign err_o      = err_q;

endmodule
